// File: rtl/universal_register.sv
// ---------------------------------------------------------------------------
// universal_register
//
// WIDTH-bit register with write enable and eight operating modes: hold,
// parallel load, logical shift left/right, rotate left/right, increment and
// decrement. It keeps a registered carry / shifted-out / borrow flag and a
// combinational zero flag. It is the register primitive used for the
// accumulator, the shift unit and program-counter-style counters.
//
// Parameters
//   WIDTH        register width in bits (>= 2)
//   RESET_VALUE  value loaded into q while reset is high
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset (q <= RESET_VALUE, c <= 0)
//   w          in   write enable; 0 holds q and c for every mode
//   mode       in   [2:0] operation select:
//                   0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 INC, 7 DEC
//   d          in   [WIDTH-1:0] parallel load data
//   serial_in  in   bit shifted in by SHL / SHR
//   q          out  [WIDTH-1:0] register contents
//   c          out  registered carry / shifted-out bit / borrow
//   z          out  combinational, high when q == 0
// ---------------------------------------------------------------------------
module universal_register #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             w,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             c,
   output logic             z
);

   localparam logic [2:0] MODE_HOLD = 3'd0;
   localparam logic [2:0] MODE_LOAD = 3'd1;
   localparam logic [2:0] MODE_SHL  = 3'd2;
   localparam logic [2:0] MODE_SHR  = 3'd3;
   localparam logic [2:0] MODE_ROL  = 3'd4;
   localparam logic [2:0] MODE_ROR  = 3'd5;
   localparam logic [2:0] MODE_INC  = 3'd6;
   localparam logic [2:0] MODE_DEC  = 3'd7;

   logic [WIDTH-1:0] q_nxt;
   logic             c_nxt;

   // Next-state values are derived only from the current q, so every mode
   // sees the pre-edge contents. All eight encodings are decoded.
   always_comb begin
      q_nxt = q;
      c_nxt = c;
      case (mode)
         MODE_HOLD: begin
            q_nxt = q;
            c_nxt = c;
         end
         MODE_LOAD: begin
            q_nxt = d;
         end
         MODE_SHL: begin
            q_nxt = {q[WIDTH-2:0], serial_in};
            c_nxt = q[WIDTH-1];
         end
         MODE_SHR: begin
            q_nxt = {serial_in, q[WIDTH-1:1]};
            c_nxt = q[0];
         end
         MODE_ROL: begin
            q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            c_nxt = q[WIDTH-1];
         end
         MODE_ROR: begin
            q_nxt = {q[0], q[WIDTH-1:1]};
            c_nxt = q[0];
         end
         MODE_INC: begin
            // (WIDTH+1)-bit sum: the top bit is the wrap carry.
            {c_nxt, q_nxt} = {1'b0, q} + (WIDTH+1)'(1);
         end
         MODE_DEC: begin
            // Borrow is raised only when decrementing from zero.
            q_nxt = q - WIDTH'(1);
            c_nxt = (q == '0);
         end
         default: begin
            q_nxt = q;
            c_nxt = c;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= RESET_VALUE;
         c <= 1'b0;
      end else if (w) begin
         q <= q_nxt;
         c <= c_nxt;
      end
   end

   // Zero flag follows q directly, including while reset is held.
   assign z = (q == '0);

endmodule

// File: tb/tb_universal_register.sv
// ---------------------------------------------------------------------------
// tb_universal_register
//
// Scoreboard bench for universal_register (WIDTH=8). Stimulus drives inputs
// on the falling edge and pushes the expected post-edge {q,c,z} into a queue;
// a monitor pops and compares 2 time units after each rising edge. Reset
// checks are made between edges through a separate monitor trigger. A
// second instance with RESET_VALUE=8'h5A shares clk/reset and is never
// write-enabled.
// ---------------------------------------------------------------------------
module tb_universal_register;

   logic       clk;
   logic       reset;
   logic       w;
   logic [2:0] mode;
   logic [7:0] d;
   logic       serial_in;
   logic [7:0] q;
   logic       c;
   logic       z;

   logic       w2;
   logic [7:0] q2;
   logic       c2;
   logic       z2;

   localparam logic [2:0] M_HOLD = 3'd0;
   localparam logic [2:0] M_LOAD = 3'd1;
   localparam logic [2:0] M_SHL  = 3'd2;
   localparam logic [2:0] M_SHR  = 3'd3;
   localparam logic [2:0] M_ROL  = 3'd4;
   localparam logic [2:0] M_ROR  = 3'd5;
   localparam logic [2:0] M_INC  = 3'd6;
   localparam logic [2:0] M_DEC  = 3'd7;

   universal_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
      .clk       (clk),
      .reset     (reset),
      .w         (w),
      .mode      (mode),
      .d         (d),
      .serial_in (serial_in),
      .q         (q),
      .c         (c),
      .z         (z)
   );

   universal_register #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut2 (
      .clk       (clk),
      .reset     (reset),
      .w         (w2),
      .mode      (mode),
      .d         (d),
      .serial_in (serial_in),
      .q         (q2),
      .c         (c2),
      .z         (z2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      bit         sel;   // 0: dut, 1: dut2
      logic [7:0] q;
      logic       c;
      logic       z;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   event async_chk;

   task automatic check_one(input exp_t e);
      logic [7:0] aq;
      logic       ac;
      logic       az;
      aq = e.sel ? q2 : q;
      ac = e.sel ? c2 : c;
      az = e.sel ? z2 : z;
      checks++;
      if ({aq, ac, az} !== {e.q, e.c, e.z}) begin
         failures++;
         $display("FAIL %s: got q=%02h c=%0b z=%0b, expected q=%02h c=%0b z=%0b",
                  e.name, aq, ac, az, e.q, e.c, e.z);
      end
   endtask

   // Clocked monitor: compare after every rising edge.
   always @(posedge clk) begin
      #2;
      while (sb.size() > 0) check_one(sb.pop_front());
   end

   // Asynchronous monitor: compare between edges after a reset assertion.
   always @(async_chk) begin
      #1;
      while (sb.size() > 0) check_one(sb.pop_front());
   end

   task automatic op(input logic we, input logic [2:0] m, input logic [7:0] dv,
                     input logic si, input logic [7:0] eq, input logic ec,
                     input string nm);
      exp_t e;
      @(negedge clk);
      w = we;
      mode = m;
      d = dv;
      serial_in = si;
      e.name = nm;
      e.sel = 1'b0;
      e.q = eq;
      e.c = ec;
      e.z = (eq == 8'h00);
      sb.push_back(e);
   endtask

   // Assert reset between edges, check both instances before any edge,
   // then release before the next rising edge.
   task automatic reset_pulse(input string nm);
      exp_t e;
      @(negedge clk);
      #1;
      w = 1'b0;
      reset = 1'b1;
      e.name = nm; e.sel = 1'b0; e.q = 8'h00; e.c = 1'b0; e.z = 1'b1;
      sb.push_back(e);
      e.name = {nm, "_inst2"}; e.sel = 1'b1; e.q = 8'h5A; e.c = 1'b0; e.z = 1'b0;
      sb.push_back(e);
      ->async_chk;
      #2;
      reset = 1'b0;
   endtask

   logic [7:0] rol_q [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
   logic       rol_c [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      exp_t e;
      reset = 1'b1;
      w = 1'b0;
      w2 = 1'b0;
      mode = M_HOLD;
      d = 8'h00;
      serial_in = 1'b0;

      reset_pulse("reset_initial");

      // Load, then reset between edges.
      op(1'b1, M_LOAD, 8'hA5, 1'b0, 8'hA5, 1'b0, "load_a5");
      reset_pulse("reset_after_a5");

      // Write enable low holds regardless of mode.
      for (int i = 0; i < 3; i++)
         op(1'b0, M_LOAD, 8'h3C, 1'b0, 8'h00, 1'b0, $sformatf("w0_hold_%0d", i));
      op(1'b1, M_LOAD, 8'h3C, 1'b0, 8'h3C, 1'b0, "w1_load_3c");

      // Shifts.
      op(1'b1, M_LOAD, 8'h81, 1'b0, 8'h81, 1'b0, "load_81_a");
      op(1'b1, M_SHL,  8'h00, 1'b1, 8'h03, 1'b1, "shl_si1");
      op(1'b1, M_LOAD, 8'h81, 1'b0, 8'h81, 1'b1, "load_keeps_c");
      op(1'b1, M_SHR,  8'h00, 1'b0, 8'h40, 1'b1, "shr_si0_a");
      op(1'b1, M_SHR,  8'h00, 1'b0, 8'h20, 1'b0, "shr_si0_b");
      op(1'b1, M_LOAD, 8'h81, 1'b0, 8'h81, 1'b0, "load_81_b");
      op(1'b1, M_SHR,  8'h00, 1'b1, 8'hC0, 1'b1, "shr_si1");

      // Rotates.
      op(1'b1, M_LOAD, 8'h81, 1'b0, 8'h81, 1'b1, "load_81_c");
      op(1'b1, M_ROL,  8'h00, 1'b0, 8'h03, 1'b1, "rol_once");
      op(1'b1, M_LOAD, 8'h81, 1'b0, 8'h81, 1'b1, "load_81_d");
      op(1'b1, M_ROR,  8'h00, 1'b0, 8'hC0, 1'b1, "ror_once");
      op(1'b1, M_LOAD, 8'h81, 1'b0, 8'h81, 1'b1, "load_81_e");
      for (int i = 0; i < 8; i++)
         op(1'b1, M_ROL, 8'h00, 1'b0, rol_q[i], rol_c[i], $sformatf("rol_train_%0d", i));
      op(1'b1, M_HOLD, 8'hFF, 1'b1, 8'h81, 1'b1, "hold_mode");

      // Counting.
      op(1'b1, M_LOAD, 8'hFE, 1'b0, 8'hFE, 1'b1, "load_fe");
      op(1'b1, M_INC,  8'h00, 1'b0, 8'hFF, 1'b0, "inc_ff");
      op(1'b1, M_INC,  8'h00, 1'b0, 8'h00, 1'b1, "inc_wrap");
      op(1'b1, M_INC,  8'h00, 1'b0, 8'h01, 1'b0, "inc_01");
      op(1'b1, M_DEC,  8'h00, 1'b0, 8'h00, 1'b0, "dec_00");
      op(1'b1, M_DEC,  8'h00, 1'b0, 8'hFF, 1'b1, "dec_wrap");
      op(1'b0, M_INC,  8'h00, 1'b0, 8'hFF, 1'b1, "w0_inc_hold");

      // Mid-count reset.
      op(1'b1, M_LOAD, 8'h00, 1'b0, 8'h00, 1'b1, "load_00");
      for (int i = 1; i <= 5; i++)
         op(1'b1, M_INC, 8'h00, 1'b0, 8'(i), 1'b0, $sformatf("count_%0d", i));
      reset_pulse("reset_mid_count");
      for (int i = 1; i <= 3; i++)
         op(1'b1, M_INC, 8'h00, 1'b0, 8'(i), 1'b0, $sformatf("recount_%0d", i));

      // Second instance never written: holds its reset value.
      @(negedge clk);
      w = 1'b0;
      mode = M_LOAD;
      d = 8'h3C;
      e.name = "inst2_hold"; e.sel = 1'b1; e.q = 8'h5A; e.c = 1'b0; e.z = 1'b0;
      sb.push_back(e);

      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
